// File: rtl/fifo_piso_pkg.sv
// fifo_piso_pkg: shared state encoding and default word width for the FIFO drain serializer
package fifo_piso_pkg;
  localparam int WIDTH_DEF = 8;
  typedef enum logic [2:0] {IDLE, POP, LOAD, SHIFT, PARITY} state_t;
endpackage

// File: rtl/piso_shreg.sv
// piso_shreg: parallel-load shift register, shifts left on enable, MSB is the serial output
module piso_shreg #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic             shift,
  input  logic [WIDTH-1:0] din,
  output logic             msb
);
  logic [WIDTH-1:0] sr;
  always_ff @(posedge clk or posedge reset)
    if (reset) sr <= '0;
    else if (load) sr <= din;
    else if (shift) sr <= sr << 1;
  assign msb = sr[WIDTH-1];
endmodule

// File: rtl/fifo_piso_drain.sv
// fifo_piso_drain: pops words from a FIFO and emits them MSB-first as serial frames with optional even parity
module fifo_piso_drain
  import fifo_piso_pkg::*;
#(
  parameter int WIDTH     = WIDTH_DEF,
  parameter bit PARITY_EN = 1'b1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] fifo_data,
  input  logic             fifo_empty,
  input  logic             fifo_push,
  output logic             fifo_pop,
  output logic             ser_data,
  output logic             ser_valid,
  input  logic             ser_ready,
  output logic             ser_last,
  output logic [7:0]       frame_cnt
);
  localparam int CW = $clog2(WIDTH) + 1;
  state_t state, next;
  logic [CW-1:0] cnt;
  logic par, msb, acc, end_bit;
  state_t done_next;
  assign fifo_pop  = state == POP && !fifo_push && !fifo_empty;
  assign end_bit   = cnt == CW'(WIDTH - 1);
  assign ser_valid = state == SHIFT || state == PARITY;
  assign ser_data  = (state == SHIFT && msb) || (state == PARITY && par);
  assign ser_last  = state == PARITY || (state == SHIFT && end_bit && !PARITY_EN);
  assign acc       = ser_valid && ser_ready;
  // The IDLE empty-check is folded into the final-bit edge, giving the 2-cycle frame gap
  assign done_next = fifo_empty ? IDLE : POP;
  always_comb begin
    next = state;
    unique case (state)
      IDLE:    next = fifo_empty ? IDLE : POP;
      POP:     next = fifo_pop ? LOAD : fifo_push ? POP : IDLE;
      LOAD:    next = SHIFT;
      SHIFT:   next = !(acc && end_bit) ? SHIFT : PARITY_EN ? PARITY : done_next;
      PARITY:  next = acc ? done_next : PARITY;
      default: next = IDLE;
    endcase
  end
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      state     <= IDLE;
      cnt       <= '0;
      par       <= 1'b0;
      frame_cnt <= '0;
    end else begin
      state <= next;
      if (state == LOAD) begin
        cnt <= '0;
        par <= ^fifo_data;
      end else if (state == SHIFT && acc) cnt <= cnt + 1'b1;
      if (acc && ser_last) frame_cnt <= frame_cnt + 8'd1;
    end
  piso_shreg #(.WIDTH(WIDTH)) u_shreg (
    .clk   (clk),
    .reset (reset),
    .load  (state == LOAD),
    .shift (state == SHIFT && acc),
    .din   (fifo_data),
    .msb   (msb)
  );
endmodule

// File: tb/tb_fifo_piso_drain.sv
// tb_fifo_piso_drain: table vectors, directed corner sequences and a randomized queue-based reference check
module tb_fifo_piso_drain;
  logic clk = 1'b0;
  logic reset = 1'b1;
  logic [7:0] fifo_data = '0;
  logic fifo_empty = 1'b1, fifo_push = 1'b0, ser_ready = 1'b0;
  logic fifo_pop, ser_data, ser_valid, ser_last;
  logic [7:0] frame_cnt;
  int checks = 0, errors = 0, pops = 0;
  logic [7:0] q[$];
  logic rx[$], rxl[$], expq[$];
  logic s_pop, s_valid, s_data, s_last;

  typedef struct {logic [7:0] word; logic [8:0] bits;} vec_t;
  vec_t tbl[8];

  fifo_piso_drain dut (
    .clk(clk), .reset(reset), .fifo_data(fifo_data), .fifo_empty(fifo_empty),
    .fifo_push(fifo_push), .fifo_pop(fifo_pop), .ser_data(ser_data),
    .ser_valid(ser_valid), .ser_ready(ser_ready), .ser_last(ser_last),
    .frame_cnt(frame_cnt)
  );

  always #5 clk = ~clk;

  function automatic void chk(string n, logic [31:0] a, logic [31:0] e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", n, a, e);
    end
  endfunction

  // Expected frame: payload MSB first, then even parity from the ones count
  function automatic void exp_frame(logic [7:0] w);
    for (int i = 7; i >= 0; i--) expq.push_back(w[i]);
    expq.push_back(1'($countones(w) % 2));
  endfunction

  task automatic tick(input logic rdy, input logic push);
    logic [7:0] w;
    ser_ready = rdy;
    fifo_push = push;
    fifo_empty = (q.size() == 0);
    #1;
    s_pop = fifo_pop; s_valid = ser_valid; s_data = ser_data; s_last = ser_last;
    chk("pop_guard", {31'd0, s_pop & (fifo_empty | push)}, 0);
    if (s_valid && rdy) begin rx.push_back(s_data); rxl.push_back(s_last); end
    @(posedge clk); #1;
    if (s_pop && q.size() > 0) begin
      w = q.pop_front();
      fifo_data = w;
      pops++;
      exp_frame(w);
    end
    if (push) q.push_back(8'($urandom_range(0, 255)));
    fifo_empty = (q.size() == 0);
    @(negedge clk);
  endtask

  task automatic clear_model();
    q.delete(); rx.delete(); rxl.delete(); expq.delete();
    pops = 0;
    fifo_push = 1'b0;
    fifo_empty = 1'b1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    clear_model();
    ser_ready = 1'b0;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic run_bits(input int n, input int budget);
    int k = 0;
    while (rx.size() < n && k < budget) begin tick(1'b1, 1'b0); k++; end
    chk("bit_budget", {31'd0, rx.size() >= n}, 1);
  endtask

  task automatic drain(input int budget);
    int k = 0;
    while ((q.size() != 0 || rx.size() < expq.size()) && k < budget) begin tick(1'b1, 1'b0); k++; end
    chk("drain_budget", {31'd0, k < budget}, 1);
    repeat (3) tick(1'b1, 1'b0);
  endtask

  function automatic logic [8:0] first9();
    logic [8:0] v = '0;
    for (int i = 0; i < 9 && i < rx.size(); i++) v[8-i] = rx[i];
    return v;
  endfunction

  task automatic cmp_stream(string n);
    int mism = 0;
    chk({n, "_len"}, rx.size(), expq.size());
    for (int i = 0; i < rx.size() && i < expq.size(); i++) begin
      if (rx[i] !== expq[i]) mism++;
      if (rxl[i] !== (i % 9 == 8)) mism++;
    end
    chk({n, "_bits"}, mism, 0);
  endtask

  initial begin
    logic [12:0] pv, vv, lv;
    logic [8:0] dv;
    logic [3:0] rpat;
    logic d1, d2, d3;
    int di, lows, first_v, last_v;
    logic vlog[64];
    tbl = '{'{8'hA5, 9'b101001010}, '{8'h3C, 9'b001111000}, '{8'h81, 9'b100000010},
            '{8'hFF, 9'b111111110}, '{8'h01, 9'b000000011}, '{8'h00, 9'b000000000},
            '{8'h07, 9'b000001111}, '{8'h80, 9'b100000001}};

    do_reset();
    fifo_empty = 1'b1; #1;
    chk("rst_valid", {31'd0, ser_valid}, 0);
    chk("rst_data", {31'd0, ser_data}, 0);
    chk("rst_last", {31'd0, ser_last}, 0);
    chk("rst_pop", {31'd0, fifo_pop}, 0);
    chk("rst_cnt", {24'd0, frame_cnt}, 0);
    @(negedge clk);

    // Table vectors: one frame per word, compared against hand-derived bit patterns
    for (int t = 0; t < 8; t++) begin
      rx.delete(); rxl.delete(); expq.delete();
      q.push_back(tbl[t].word);
      run_bits(9, 40);
      repeat (2) tick(1'b1, 1'b0);
      chk($sformatf("tbl%0d_bits", t), {23'd0, first9()}, {23'd0, tbl[t].bits});
      chk($sformatf("tbl%0d_len", t), rx.size(), 9);
      chk($sformatf("tbl%0d_cnt", t), {24'd0, frame_cnt}, t + 1);
    end

    // Latency and exact cycle placement for 0xA5
    do_reset();
    q.push_back(8'hA5);
    pv = '0; vv = '0; lv = '0; dv = '0; di = 0;
    for (int c = 0; c < 13; c++) begin
      tick(1'b1, 1'b0);
      pv[c] = s_pop; vv[c] = s_valid; lv[c] = s_last;
      if (s_valid && di < 9) begin dv[8-di] = s_data; di++; end
    end
    chk("lat_pop", {19'd0, pv}, 32'h0002);
    chk("lat_valid", {19'd0, vv}, 32'h0FF8);
    chk("lat_last", {19'd0, lv}, 32'h0800);
    chk("lat_bits", {23'd0, dv}, {23'd0, 9'b101001010});
    chk("lat_cnt", {24'd0, frame_cnt}, 1);

    // Push collision holds off the pop for three cycles
    do_reset();
    q.push_back(8'h3C);
    tick(1'b1, 1'b0);
    pv = '0;
    for (int c = 0; c < 3; c++) begin tick(1'b1, 1'b1); pv[c] = s_pop; end
    tick(1'b1, 1'b0);
    pv[3] = s_pop;
    chk("push_pop_seq", {28'd0, pv[3:0]}, 32'h8);
    run_bits(9, 40);
    chk("push_bits", {23'd0, first9()}, {23'd0, 9'b001111000});

    // Downstream stalls during SHIFT of 0x81
    do_reset();
    q.push_back(8'h81);
    repeat (3) tick(1'b1, 1'b0);
    rpat = 4'b1001;
    d1 = 1'b0; d2 = 1'b0; d3 = 1'b0;
    for (int c = 0; c < 4; c++) begin
      tick(rpat[3-c], 1'b0);
      chk($sformatf("stall_valid%0d", c), {31'd0, s_valid}, 1);
      if (c == 1) d1 = s_data;
      if (c == 2) d2 = s_data;
      if (c == 3) d3 = s_data;
    end
    chk("stall_hold", {30'd0, d1 ^ d2, d2 ^ d3}, 0);
    run_bits(9, 40);
    repeat (4) tick(1'b1, 1'b0);
    chk("stall_len", rx.size(), 9);
    chk("stall_bits", {23'd0, first9()}, {23'd0, 9'b100000010});

    // Reset in the middle of a 0xFF frame
    do_reset();
    q.push_back(8'hFF);
    run_bits(4, 40);
    #2 reset = 1'b1;
    #1;
    chk("mid_rst_valid", {31'd0, ser_valid}, 0);
    chk("mid_rst_data", {31'd0, ser_data}, 0);
    chk("mid_rst_cnt", {24'd0, frame_cnt}, 0);
    clear_model();
    @(negedge clk);
    reset = 1'b0;
    repeat (3) tick(1'b1, 1'b0);
    chk("mid_rst_quiet", rx.size(), 0);
    q.push_back(8'h01);
    run_bits(9, 40);
    repeat (3) tick(1'b1, 1'b0);
    chk("mid_rst_bits", {23'd0, first9()}, {23'd0, 9'b000000011});
    chk("mid_rst_len", rx.size(), 9);
    chk("mid_rst_cnt2", {24'd0, frame_cnt}, 1);

    // Back-to-back frames: two idle cycles between frames
    do_reset();
    repeat (3) q.push_back(8'($urandom_range(0, 255)));
    for (int c = 0; c < 64; c++) begin tick(1'b1, 1'b0); vlog[c] = s_valid; end
    first_v = -1; last_v = -1; lows = 0; di = 0;
    for (int c = 0; c < 64; c++) if (vlog[c]) begin
      if (first_v < 0) first_v = c;
      last_v = c;
      di++;
    end
    for (int c = 0; c < 64; c++) if (c > first_v && c < last_v && !vlog[c]) lows++;
    chk("b2b_valid_cycles", di, 27);
    chk("b2b_gap_cycles", lows, 4);
    cmp_stream("b2b");

    // 256 preloaded words: frame counter wraps and every pop is accounted for
    do_reset();
    repeat (256) q.push_back(8'($urandom_range(0, 255)));
    drain(256 * 12 + 100);
    chk("wrap_pops", pops, 256);
    chk("wrap_cnt", {24'd0, frame_cnt}, 0);
    cmp_stream("wrap");

    // Randomized ready, push collisions and FIFO underflow
    do_reset();
    repeat (5) q.push_back(8'($urandom_range(0, 255)));
    for (int c = 0; c < 3000; c++) tick($urandom_range(0, 3) != 0, $urandom_range(0, 7) == 0);
    drain(6000);
    chk("rand_cnt", {24'd0, frame_cnt}, pops % 256);
    cmp_stream("rand");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
